// File: rtl/hub75_column_fetch_if.sv
// Line stream from the column fetcher to the HUB75 scan driver.
// One scan line per tvalid/tready handshake.
interface hub75_column_fetch_if #(
  parameter int NUM_ROWS  = 64,
  parameter int RGB_RES   = 9,
  parameter int SCAN_RATE = 32
) ();
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] column_data;
  logic [$clog2(SCAN_RATE)-1:0]          address_data;
  logic                                  tvalid;
  logic                                  tready;
  logic                                  slice_done;

  modport master (
    output column_data, address_data, tvalid, slice_done,
    input  tready
  );

  modport slave (
    input  column_data, address_data, tvalid, slice_done,
    output tready
  );
endinterface

// File: rtl/hub75_column_fetch.sv
// Voxel BRAM line fetcher with ping-pong line banks for the HUB75 driver.
// HUB75_FETCH_TEST_PATTERN_EN replaces BRAM data with a generated pattern.
module hub75_column_fetch #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 64,
  parameter int SCAN_RATE    = 32,
  parameter int THETA_RES    = 8,
  parameter int RGB_RES      = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [THETA_RES-1:0] theta_in,
  input  logic                 theta_valid,
  output logic [THETA_RES+$clog2(SCAN_RATE)+$clog2(NUM_COLS)-1:0] bram_addr,
  output logic                 bram_en,
  input  logic [2*RGB_RES-1:0] bram_data,
  hub75_column_fetch_if.master m_if
);
  localparam int LW = $clog2(SCAN_RATE);
  localparam int PW = $clog2(NUM_COLS);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int AW = THETA_RES + LW + PW;
  localparam int L  = READ_LATENCY;
  localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_COLS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(SCAN_RATE - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;
  typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] line_t;

  state_e state_q, state_d;
  logic [THETA_RES-1:0] theta_q, theta_d;
  logic [THETA_RES-1:0] pend_theta_q, pend_theta_d;
  logic pend_q, pend_d;
  logic [LW-1:0] line_q, line_d;
  logic [PW-1:0] pix_q, pix_d;
  logic issue_q, issue_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [L-1:0] vld_q, vld_d;
  logic [L-1:0][PW-1:0] idx_q, idx_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  line_t [1:0] bank_q, bank_d;
  logic [1:0][LW-1:0] bank_line_q, bank_line_d;

  logic hs, wr_vld, done, consume, launch;
  logic [PW-1:0] wr_idx;
  logic [RW-1:0] wr_row;
  logic [RGB_RES-1:0] px_up, px_lo;

  assign wr_vld = vld_q[L-1];
  assign wr_idx = idx_q[L-1];
  assign wr_row = RW'(wr_idx);
  assign done   = wr_vld && (wr_idx == PIX_LAST);
  assign hs     = full_q[rd_bank_q] & m_if.tready;

`ifdef HUB75_FETCH_TEST_PATTERN_EN
  logic unused_bram;
  assign unused_bram = ^bram_data;
  assign px_up   = RGB_RES'({wr_idx[2:0], line_q[2:0], theta_q[2:0]});
  assign px_lo   = ~px_up;
  assign bram_en = 1'b0;
`else
  assign px_up   = bram_data[RGB_RES-1:0];
  assign px_lo   = bram_data[2*RGB_RES-1:RGB_RES];
  assign bram_en = issue_q;
`endif

  assign bram_addr         = addr_q;
  assign m_if.tvalid       = full_q[rd_bank_q];
  assign m_if.column_data  = bank_q[rd_bank_q];
  assign m_if.address_data = bank_line_q[rd_bank_q];
  assign m_if.slice_done   = hs && (bank_line_q[rd_bank_q] == LINE_LAST);

  always_comb begin
    state_d      = state_q;
    theta_d      = theta_q;
    pend_theta_d = pend_theta_q;
    pend_d       = pend_q;
    line_d       = line_q;
    pix_d        = pix_q;
    issue_d      = issue_q;
    addr_d       = addr_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_d       = bank_q;
    bank_line_d  = bank_line_q;
    consume      = 1'b0;
    launch       = 1'b0;

    // Return pipe tracks which pixel each BRAM read belongs to.
    vld_d[0] = issue_q;
    idx_d[0] = pix_q;
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end

    if (hs) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (wr_vld) begin
      bank_d[wr_bank_q][0][wr_row] = px_up;
      bank_d[wr_bank_q][1][wr_row] = px_lo;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          theta_d = pend_theta_q;
          line_d  = '0;
          consume = 1'b1;
          launch  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (issue_q) begin
          if (pix_q == PIX_LAST) begin
            issue_d = 1'b0;
          end else begin
            pix_d  = pix_q + 1'b1;
            addr_d = {theta_q, line_q, pix_d};
          end
        end
        if (done) begin
          full_d[wr_bank_q]      = 1'b1;
          bank_line_d[wr_bank_q] = line_q;
          wr_bank_d              = ~wr_bank_q;
          if (line_q == LINE_LAST) begin
            line_d = '0;
            if (pend_q) begin
              theta_d = pend_theta_q;
              consume = 1'b1;
            end
          end else begin
            line_d = line_q + 1'b1;
          end
          if (!full_d[wr_bank_d]) launch = 1'b1;
          else state_d = HOLD;
        end
      end
      HOLD: begin
        if (!full_d[wr_bank_q]) begin
          launch  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      issue_d = 1'b1;
      pix_d   = '0;
      addr_d  = {theta_d, line_d, {PW{1'b0}}};
    end

    // A strobe landing on the consuming edge stays pending.
    if (consume) pend_d = 1'b0;
    if (theta_valid) begin
      pend_d       = 1'b1;
      pend_theta_d = theta_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      theta_q      <= '0;
      pend_theta_q <= '0;
      pend_q       <= 1'b0;
      line_q       <= '0;
      pix_q        <= '0;
      issue_q      <= 1'b0;
      addr_q       <= '0;
      vld_q        <= '0;
      idx_q        <= '0;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_q       <= '0;
      bank_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      theta_q      <= theta_d;
      pend_theta_q <= pend_theta_d;
      pend_q       <= pend_d;
      line_q       <= line_d;
      pix_q        <= pix_d;
      issue_q      <= issue_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_q       <= bank_d;
      bank_line_q  <= bank_line_d;
    end
  end
endmodule

// File: tb/tb_hub75_column_fetch.sv
// Bench for hub75_column_fetch: line-level model of presented scan lines,
// directed theta/tready/reset scenarios and a few pinned literals.
module tb_hub75_column_fetch;
  localparam int NC = 64;
  localparam int NR = 64;
  localparam int SR = 32;
  localparam int TR = 8;
  localparam int RR = 9;
  localparam int RL = 2;
  localparam int AW = TR + 5 + 6;

  typedef logic [1:0][NR-1:0][RR-1:0] line_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic [TR-1:0] theta_in = '0;
  logic theta_valid = 1'b0;
  logic [AW-1:0] bram_addr;
  logic bram_en;
  logic [2*RR-1:0] bram_data = '0;
  logic [2*RR-1:0] rd_p1 = '0;

  hub75_column_fetch_if #(
    .NUM_ROWS(NR), .RGB_RES(RR), .SCAN_RATE(SR)
  ) s_if ();

  hub75_column_fetch #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_RATE(SR),
    .THETA_RES(TR), .RGB_RES(RR), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .theta_in(theta_in),
    .theta_valid(theta_valid),
    .bram_addr(bram_addr),
    .bram_en(bram_en),
    .bram_data(bram_data),
    .m_if(s_if)
  );

  always #5 clk = ~clk;

  function automatic logic [RR-1:0] w_up(input logic [AW-1:0] a);
    return a[8:0];
  endfunction

  function automatic logic [RR-1:0] w_lo(input logic [AW-1:0] a);
    logic [9:0] s;
    s = a[9:0] + 10'd1;
    return s[8:0] ^ {a[13:11], 6'd0};
  endfunction

  // Two-cycle BRAM returning a word derived from its address.
  always @(posedge clk) begin
    if (bram_en) rd_p1 <= {w_lo(bram_addr), w_up(bram_addr)};
    bram_data <= rd_p1;
  end

  function automatic line_t exp_data(input logic [TR-1:0] t,
                                     input logic [4:0] l);
    line_t v;
    logic [AW-1:0] a;
    v = '0;
    for (int p = 0; p < NC; p++) begin
      a = {t, l, 6'(p)};
`ifdef HUB75_FETCH_TEST_PATTERN_EN
      v[0][p] = {a[2:0], l[2:0], t[2:0]};
      v[1][p] = ~v[0][p];
`else
      v[0][p] = w_up(a);
      v[1][p] = w_lo(a);
`endif
    end
    return v;
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_col(input string nm, input line_t act,
                         input line_t exp);
    int h, r;
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      h = 0;
      r = 0;
      for (int i = 0; i < 2; i++)
        for (int j = NR - 1; j >= 0; j--)
          if (act[i][j] !== exp[i][j]) begin
            h = i;
            r = j;
          end
      $display("FAIL %s: half %0d row %0d got %0h expected %0h",
               nm, h, r, act[h][r], exp[h][r]);
    end
  endtask

  // Line-level model: which (theta, line) the next handshake carries.
  bit m_idle = 1'b1;
  logic [TR-1:0] m_theta = '0;
  bit m_has_next = 1'b0;
  logic [TR-1:0] m_next = '0;
  int m_line = 0;
  int hs_cnt = 0;
  int sd_cnt = 0;
  int str_seq = 0;
  int seen_seq = 0;
  logic [TR-1:0] str_val = '0;
  bit prev_hold = 1'b0;
  line_t prev_col;
  logic [4:0] prev_addr;

  always @(negedge clk) begin
    if (!rst_in) begin
      m_idle = 1'b1;
      m_has_next = 1'b0;
      m_line = 0;
      prev_hold = 1'b0;
    end else begin
      if (str_seq != seen_seq) begin
        seen_seq = str_seq;
        if (m_idle) begin
          m_idle = 1'b0;
          m_theta = str_val;
          m_line = 0;
        end else begin
          m_has_next = 1'b1;
          m_next = str_val;
        end
      end
      if (prev_hold) begin
        chk("hold_tvalid", s_if.tvalid, 1);
        chk_col("hold_col", s_if.column_data, prev_col);
        chk("hold_addr", s_if.address_data, prev_addr);
      end
      if (m_idle) chk("idle_tvalid", s_if.tvalid, 0);
`ifdef HUB75_FETCH_TEST_PATTERN_EN
      chk("pat_bram_en", bram_en, 0);
`endif
      if (s_if.slice_done) sd_cnt++;
      if (s_if.tvalid && s_if.tready) begin
        chk("hs_addr", s_if.address_data, m_line);
        chk_col("hs_data", s_if.column_data,
                exp_data(m_theta, 5'(m_line)));
        chk("hs_slice_done", s_if.slice_done, m_line == SR - 1);
        hs_cnt++;
        if (m_line == SR - 1) begin
          m_line = 0;
          if (m_has_next) begin
            m_theta = m_next;
            m_has_next = 1'b0;
          end
        end else begin
          m_line++;
        end
      end else begin
        chk("idle_slice_done", s_if.slice_done, 0);
      end
      prev_hold = s_if.tvalid && !s_if.tready;
      prev_col = s_if.column_data;
      prev_addr = s_if.address_data;
    end
  end

  task automatic strobe(input logic [TR-1:0] t);
    @(posedge clk);
    #1;
    theta_in = t;
    theta_valid = 1'b1;
    str_val = t;
    str_seq++;
    @(posedge clk);
    #1;
    theta_valid = 1'b0;
  endtask

  // Strobe from IDLE and time the first line to tvalid.
  task automatic launch(input logic [TR-1:0] t);
    int cyc, first_en;
    strobe(t);
    cyc = 0;
    first_en = -1;
    while (!s_if.tvalid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bram_en && first_en < 0) begin
        first_en = cyc;
        chk("first_theta", bram_addr[18:11], t);
        chk("first_lowaddr", bram_addr[10:0], 0);
      end
    end
    chk("first_latency", cyc, 1 + NC + RL);
`ifdef HUB75_FETCH_TEST_PATTERN_EN
    chk("first_en_cycle", first_en, -1);
`else
    chk("first_en_cycle", first_en, 1);
`endif
  endtask

  task automatic wait_hs(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (hs_cnt < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(nm, hs_cnt >= n, 1);
  endtask

  task automatic wait_model(input logic [TR-1:0] t, input int l,
                            input int budget, input string nm);
    int c;
    c = 0;
    while (!(m_theta == t && m_line == l) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(nm, m_theta == t && m_line == l, 1);
  endtask

  initial begin
    int h0, s0, c;
    bit bad_en, bad_v;
    s_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b1;
    chk("rst_tvalid", s_if.tvalid, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_addr_data", s_if.address_data, 0);
    chk("rst_slice_done", s_if.slice_done, 0);
    chk_col("rst_col", s_if.column_data, '0);

    launch(8'h05);
    chk("l0_addr", s_if.address_data, 0);
`ifdef HUB75_FETCH_TEST_PATTERN_EN
    chk("l0_up5", s_if.column_data[0][5], 9'b101_000_101);
    chk("l0_lo0", s_if.column_data[1][0], 9'b111_111_010);
`else
    chk("l0_up5", s_if.column_data[0][5], 9'd5);
    chk("l0_lo0", s_if.column_data[1][0], 9'h141);
`endif

    // Continuous refresh of one theta.
    wait_hs(70, 70 * 80, "wait_refresh");
    chk("refresh_slice_done", sd_cnt, 2);

    // Downstream stall: both banks fill, fetch stops.
    s_if.tready = 1'b0;
    repeat (200) @(posedge clk);
    bad_en = 1'b0;
    bad_v = 1'b0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (bram_en) bad_en = 1'b1;
      if (!s_if.tvalid) bad_v = 1'b1;
    end
    chk("stall_bram_en", bad_en, 0);
    chk("stall_tvalid_drop", bad_v, 0);
    h0 = hs_cnt;
    s_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_handshakes", hs_cnt - h0, 2);

    // New theta takes effect only at the next slice.
    c = 0;
    while (m_line != 2 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("wait_line2", m_line, 2);
    strobe(8'h03);
    wait_model(8'h03, 10, 5000, "wait_t3_l10");
    strobe(8'h07);
    s0 = sd_cnt;
    wait_model(8'h07, 3, 3000, "wait_t7_l3");
    chk("t37_slice_done", sd_cnt - s0, 1);

    // Reset in the middle of a fill.
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    strobe(8'h04);
    repeat (30) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    chk("mid_rst_tvalid", s_if.tvalid, 0);
    chk("mid_rst_bram_en", bram_en, 0);
    chk("mid_rst_bram_addr", bram_addr, 0);
    chk_col("mid_rst_col", s_if.column_data, '0);
    bad_en = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (bram_en || s_if.tvalid) bad_en = 1'b1;
    end
    chk("quiet_500", bad_en, 0);
    chk_col("quiet_col", s_if.column_data, '0);

    // Recovery after reset, line 1 pixel 4 pinned.
    launch(8'h02);
    c = 0;
    while (!(s_if.tvalid && s_if.address_data == 1) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("wait_t2_l1", s_if.address_data, 1);
`ifdef HUB75_FETCH_TEST_PATTERN_EN
    chk("t2_l1_up4", s_if.column_data[0][4], 9'b100_001_010);
    chk("t2_l1_lo4", s_if.column_data[1][4], 9'b011_110_101);
`else
    chk("t2_l1_up4", s_if.column_data[0][4], 9'h044);
    chk("t2_l1_lo4", s_if.column_data[1][4], 9'h0C5);
`endif
    h0 = hs_cnt;
    wait_hs(h0 + 3, 400, "wait_tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
